// File: rtl/wide_alu_pkg.sv
// Shared types for the wide ALU and its initiator-side controller.
// Operation codes 6 and 7 are deliberately left unassigned; the ALU flags them as ERROR_OPCODE.
package wide_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } optype_e;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PENDING      = 2'd1,
        ST_ERROR_WRITE  = 2'd2,
        ST_ERROR_OPCODE = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        RSP_OK          = 2'd0,
        RSP_ERR_OPCODE  = 2'd1,
        RSP_ERR_WRITE   = 2'd2,
        RSP_ERR_TIMEOUT = 2'd3
    } rsp_code_e;

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_IDLE    = 3'd1,
        S_CFG     = 3'd2,
        S_TRIG    = 3'd3,
        S_WAIT    = 3'd4,
        S_CLEAR   = 3'd5,
        S_CLRWAIT = 3'd6,
        S_RESP    = 3'd7
    } ctrl_state_e;

    function automatic logic status_is_err(input status_e s);
        return (s == ST_ERROR_WRITE) || (s == ST_ERROR_OPCODE);
    endfunction

    function automatic rsp_code_e err_code(input status_e s);
        return (s == ST_ERROR_WRITE) ? RSP_ERR_WRITE : RSP_ERR_OPCODE;
    endfunction

endpackage

// File: rtl/wide_alu_ctrl.sv
// Drives one wide-ALU operation per command and returns result or error code; rsp_valid at T+4+D.
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready, so no new command is taken meanwhile.
module wide_alu_ctrl
    import wide_alu_pkg::*;
#(
    parameter int ALU_WIDTH      = 256,
    parameter int DEACCEL_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  optype_e                    cmd_op_i,
    input  logic [DEACCEL_WIDTH-1:0]   cmd_deaccel_i,
    input  logic [ALU_WIDTH-1:0]       cmd_op_a_i,
    input  logic [ALU_WIDTH-1:0]       cmd_op_b_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [2*ALU_WIDTH-1:0]     rsp_result_o,
    output rsp_code_e                  rsp_code_o,
    output logic                       alu_trigger_o,
    output logic                       alu_clear_err_o,
    output logic [ALU_WIDTH-1:0]       alu_op_a_o,
    output logic [ALU_WIDTH-1:0]       alu_op_b_o,
    output logic                       alu_op_sel_we_o,
    output optype_e                    alu_op_sel_o,
    output logic                       alu_deaccel_we_o,
    output logic [DEACCEL_WIDTH-1:0]   alu_deaccel_o,
    input  status_e                    alu_status_i,
    input  logic [2*ALU_WIDTH-1:0]     alu_result_i
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

    ctrl_state_e     state_q;
    status_e         status_q;
    logic            seen_pending_q;
    logic            from_sync_q;
    logic [WD_W-1:0] wd_cnt_q;

    logic status_chg;
    logic wd_watch;
    logic wd_expired;

    assign status_chg = (alu_status_i != status_q);
    assign wd_watch   = (state_q == S_WAIT) || (state_q == S_CLRWAIT) || (state_q == S_SYNC);
    assign wd_expired = !status_chg && (wd_cnt_q == WD_MAX - 1'b1);

    // Counts consecutive cycles with an unchanged ALU status; saturates so CLRWAIT/SYNC can wait forever.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= ST_IDLE;
            wd_cnt_q <= '0;
        end else begin
            status_q <= alu_status_i;
            if (!wd_watch || status_chg) begin
                wd_cnt_q <= '0;
            end else if (wd_cnt_q != WD_MAX) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= S_SYNC;
            cmd_ready_o      <= 1'b0;
            rsp_valid_o      <= 1'b0;
            rsp_result_o     <= '0;
            rsp_code_o       <= RSP_OK;
            alu_trigger_o    <= 1'b0;
            alu_clear_err_o  <= 1'b0;
            alu_op_sel_we_o  <= 1'b0;
            alu_deaccel_we_o <= 1'b0;
            alu_op_a_o       <= '0;
            alu_op_b_o       <= '0;
            alu_op_sel_o     <= OP_ADD;
            alu_deaccel_o    <= DEACCEL_WIDTH'(1);
            seen_pending_q   <= 1'b0;
            from_sync_q      <= 1'b0;
        end else begin
            alu_trigger_o    <= 1'b0;
            alu_clear_err_o  <= 1'b0;
            alu_op_sel_we_o  <= 1'b0;
            alu_deaccel_we_o <= 1'b0;
            case (state_q)
                // The ALU keeps running across our reset, so wait until it is quiet before taking commands.
                S_SYNC: begin
                    if (alu_status_i == ST_IDLE) begin
                        cmd_ready_o <= 1'b1;
                        state_q     <= S_IDLE;
                    end else if (status_is_err(alu_status_i)) begin
                        from_sync_q     <= 1'b1;
                        alu_clear_err_o <= 1'b1;
                        state_q         <= S_CLEAR;
                    end
                end
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_ready_o      <= 1'b0;
                        alu_op_a_o       <= cmd_op_a_i;
                        alu_op_b_o       <= cmd_op_b_i;
                        alu_op_sel_o     <= cmd_op_i;
                        alu_deaccel_o    <= (cmd_deaccel_i == '0) ? DEACCEL_WIDTH'(1) : cmd_deaccel_i;
                        alu_op_sel_we_o  <= 1'b1;
                        alu_deaccel_we_o <= 1'b1;
                        seen_pending_q   <= 1'b0;
                        state_q          <= S_CFG;
                    end
                end
                S_CFG: begin
                    alu_trigger_o <= 1'b1;
                    state_q       <= S_TRIG;
                end
                S_TRIG: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_status_i == ST_PENDING) begin
                        seen_pending_q <= 1'b1;
                    end
                    if (alu_status_i == ST_IDLE && seen_pending_q) begin
                        rsp_result_o <= alu_result_i;
                        rsp_code_o   <= RSP_OK;
                        rsp_valid_o  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (status_is_err(alu_status_i)) begin
                        rsp_result_o    <= '0;
                        rsp_code_o      <= err_code(alu_status_i);
                        from_sync_q     <= 1'b0;
                        alu_clear_err_o <= 1'b1;
                        state_q         <= S_CLEAR;
                    end else if (wd_expired) begin
                        rsp_result_o <= '0;
                        rsp_code_o   <= RSP_ERR_TIMEOUT;
                        rsp_valid_o  <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_CLEAR: begin
                    state_q <= S_CLRWAIT;
                end
                S_CLRWAIT: begin
                    if (alu_status_i == ST_IDLE) begin
                        if (from_sync_q) begin
                            cmd_ready_o <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            rsp_valid_o <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        // After a timeout the ALU may still be busy; resync so no write lands on a PENDING ALU.
                        if (rsp_code_o == RSP_ERR_TIMEOUT) begin
                            state_q <= S_SYNC;
                        end else begin
                            cmd_ready_o <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    cmd_ready_o <= 1'b0;
                    rsp_valid_o <= 1'b0;
                    state_q     <= S_SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_alu_ctrl.sv
// Directed bench for wide_alu_ctrl with a behavioural wide-ALU model that is not reset by rst.
module tb_wide_alu_ctrl;
    import wide_alu_pkg::*;

    localparam int AW = 256;
    localparam int DW = 8;
    localparam int RW = 512;
    localparam int NV = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    optype_e         cmd_op = OP_ADD;
    logic [DW-1:0]   cmd_deaccel = '0;
    logic [AW-1:0]   cmd_a = '0;
    logic [AW-1:0]   cmd_b = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [RW-1:0]   rsp_result;
    rsp_code_e       rsp_code;
    logic            alu_trigger;
    logic            alu_clear_err;
    logic [AW-1:0]   alu_op_a;
    logic [AW-1:0]   alu_op_b;
    logic            alu_op_sel_we;
    optype_e         alu_op_sel;
    logic            alu_deaccel_we;
    logic [DW-1:0]   alu_deaccel;
    status_e         alu_status = ST_IDLE;
    logic [RW-1:0]   alu_result = '0;

    always #5 clk = ~clk;

    wide_alu_ctrl #(.ALU_WIDTH(AW), .DEACCEL_WIDTH(DW), .TIMEOUT_CYCLES(1024)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_deaccel_i(cmd_deaccel), .cmd_op_a_i(cmd_a), .cmd_op_b_i(cmd_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .rsp_code_o(rsp_code), .alu_trigger_o(alu_trigger), .alu_clear_err_o(alu_clear_err),
        .alu_op_a_o(alu_op_a), .alu_op_b_o(alu_op_b), .alu_op_sel_we_o(alu_op_sel_we),
        .alu_op_sel_o(alu_op_sel), .alu_deaccel_we_o(alu_deaccel_we), .alu_deaccel_o(alu_deaccel),
        .alu_status_i(alu_status), .alu_result_i(alu_result)
    );

    // ---------------- ALU model ----------------
    logic [2:0]    m_op = 3'd0;
    logic [DW-1:0] m_deaccel = 8'd1;
    logic [8:0]    m_cnt = '0;
    logic          alu_stuck = 1'b0;
    int            we_in_pending = 0;

    function automatic logic [RW-1:0] alu_fn(input logic [2:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b);
        case (op)
            3'd0: return {256'd0, a} + {256'd0, b};
            3'd1: return {256'd0, a - b};
            3'd2: return {256'd0, a} * {256'd0, b};
            3'd3: return {256'd0, a & b};
            3'd4: return {256'd0, a | b};
            3'd5: return {256'd0, a ^ b};
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_clear_err) begin
            alu_status <= ST_IDLE;
        end else if ((alu_op_sel_we || alu_deaccel_we) && alu_status == ST_PENDING) begin
            alu_status    <= ST_ERROR_WRITE;
            we_in_pending <= we_in_pending + 1;
        end else if (alu_trigger) begin
            if (m_op > 3'd5) begin
                alu_status <= ST_ERROR_OPCODE;
            end else begin
                alu_status <= ST_PENDING;
                m_cnt      <= (m_deaccel == '0) ? 9'd256 : {1'b0, m_deaccel};
            end
        end else if (alu_status == ST_PENDING && !alu_stuck) begin
            if (m_cnt <= 9'd1) begin
                alu_status <= ST_IDLE;
                alu_result <= alu_fn(m_op, alu_op_a, alu_op_b);
            end else begin
                m_cnt <= m_cnt - 9'd1;
            end
        end
        if (alu_op_sel_we) m_op <= alu_op_sel;
        if (alu_deaccel_we) m_deaccel <= alu_deaccel;
    end

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            n_trig = 0, n_clr = 0;
    int            we_cyc = -1, dwe_cyc = -1, trig_cyc = -1;
    logic [2:0]    we_op = '0;
    logic [DW-1:0] we_deaccel = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (alu_op_sel_we) begin
            we_cyc <= cyc;
            we_op  <= alu_op_sel;
        end
        if (alu_deaccel_we) begin
            dwe_cyc    <= cyc;
            we_deaccel <= alu_deaccel;
        end
        if (alu_trigger) begin
            n_trig   <= n_trig + 1;
            trig_cyc <= cyc;
        end
        if (alu_clear_err) n_clr <= n_clr + 1;
    end

    // ---------------- checking helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, output int t_hs);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = optype_e'(op);
        cmd_deaccel = d;
        cmd_a       = a;
        cmd_b       = b;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        t_hs = cyc;
        chk("cmd_accepted", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_a     = ~a;
        cmd_b     = ~b;
        cmd_op    = OP_MUL;
    endtask

    task automatic wait_rsp(input int budget, input logic [AW-1:0] a, input logic [AW-1:0] b,
                            output int t_rsp, output logic [RW-1:0] res, output rsp_code_e code,
                            output int op_bad);
        int n;
        n = 0;
        op_bad = 0;
        while (!rsp_valid && n < budget) begin
            if (alu_op_a !== a || alu_op_b !== b) op_bad++;
            @(negedge clk);
            n++;
        end
        chk("rsp_valid_seen", rsp_valid, 1);
        t_rsp = cyc;
        res   = rsp_result;
        code  = rsp_code;
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [RW-1:0] res;
        rsp_code_e     code;
        int            lat;
        logic [DW-1:0] d_wr;
        int            clr;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [DW-1:0] d, input logic [AW-1:0] a,
                                input logic [AW-1:0] b, input logic [RW-1:0] res, input rsp_code_e code,
                                input int lat, input logic [DW-1:0] d_wr, input int clr);
        vec_t v;
        v.op = op; v.d = d; v.a = a; v.b = b; v.res = res;
        v.code = code; v.lat = lat; v.d_wr = d_wr; v.clr = clr;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t          vecs [NV];
        logic [AW-1:0] ones;
        logic [AW-1:0] a_big;
        logic [RW-1:0] r_2p256;
        logic [RW-1:0] r_sq;
        int            t_hs, t_rsp, op_bad, tr0, cl0, bad, n;
        logic [RW-1:0] res;
        rsp_code_e     code;

        ones    = '1;
        a_big   = {1'b1, 255'd0};
        r_2p256 = {255'd0, 1'b1, 256'd0};
        r_sq    = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};

        vecs[0] = mk(3'd0, 8'd1, 256'd5,   256'd7, 512'd12,  RSP_OK,         5, 8'd1, 0);
        vecs[1] = mk(3'd2, 8'd4, a_big,    256'd2, r_2p256,  RSP_OK,         8, 8'd4, 0);
        vecs[2] = mk(3'd7, 8'd1, 256'd5,   256'd7, 512'd0,   RSP_ERR_OPCODE, 6, 8'd1, 1);
        vecs[3] = mk(3'd0, 8'd0, 256'd5,   256'd7, 512'd12,  RSP_OK,         5, 8'd1, 0);
        vecs[4] = mk(3'd0, 8'd3, ones,     256'd1, r_2p256,  RSP_OK,         7, 8'd3, 0);
        vecs[5] = mk(3'd2, 8'd2, ones,     ones,   r_sq,     RSP_OK,         6, 8'd2, 0);
        vecs[6] = mk(3'd1, 8'd1, 256'd100, 256'd1, 512'd99,  RSP_OK,         5, 8'd1, 0);
        vecs[7] = mk(3'd6, 8'd2, 256'd3,   256'd4, 512'd0,   RSP_ERR_OPCODE, 6, 8'd2, 1);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_code", rsp_code, RSP_OK);
        chk("rst_pulses", {alu_trigger, alu_clear_err, alu_op_sel_we, alu_deaccel_we}, 0);
        chk("rst_operands", {alu_op_a, alu_op_b}, 0);
        chk("rst_op_sel", alu_op_sel, OP_ADD);
        chk("rst_deaccel", alu_deaccel, 1);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("sync_to_idle_ready", cmd_ready, 1);

        // Table-driven single operations
        for (int i = 0; i < NV; i++) begin
            tr0 = n_trig;
            cl0 = n_clr;
            send(vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].b, t_hs);
            wait_rsp(2000, vecs[i].a, vecs[i].b, t_rsp, res, code, op_bad);
            chk($sformatf("v%0d_result", i), res, vecs[i].res);
            chk($sformatf("v%0d_code", i), code, vecs[i].code);
            chk($sformatf("v%0d_latency", i), t_rsp - t_hs, vecs[i].lat);
            chk($sformatf("v%0d_we_time", i), {we_cyc - t_hs, dwe_cyc - t_hs}, {32'd1, 32'd1});
            chk($sformatf("v%0d_trig_time", i), trig_cyc - t_hs, 2);
            chk($sformatf("v%0d_op_sel", i), we_op, vecs[i].op);
            chk($sformatf("v%0d_deaccel_wr", i), we_deaccel, vecs[i].d_wr);
            chk($sformatf("v%0d_trig_count", i), n_trig - tr0, 1);
            chk($sformatf("v%0d_clear_count", i), n_clr - cl0, vecs[i].clr);
            chk($sformatf("v%0d_operands_stable", i), op_bad, 0);
            @(negedge clk);
            chk($sformatf("v%0d_rsp_dropped", i), rsp_valid, 0);
            chk($sformatf("v%0d_ready_again", i), cmd_ready, 1);
            chk($sformatf("v%0d_alu_idle", i), alu_status, ST_IDLE);
        end

        // Response backpressure, then back-to-back command
        rsp_ready = 1'b0;
        send(3'd0, 8'd1, 256'd5, 256'd7, t_hs);
        wait_rsp(100, 256'd5, 256'd7, t_rsp, res, code, op_bad);
        chk("bp_latency", t_rsp - t_hs, 5);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_result !== 512'd12 || rsp_code !== RSP_OK || cmd_ready) bad++;
        end
        chk("bp_hold_stable", bad, 0);
        rsp_ready   = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = OP_ADD;
        cmd_deaccel = 8'd1;
        cmd_a       = 256'd20;
        cmd_b       = 256'd22;
        @(negedge clk);
        chk("b2b_rsp_dropped", rsp_valid, 0);
        chk("b2b_ready_next", cmd_ready, 1);
        t_hs = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp(100, 256'd20, 256'd22, t_rsp, res, code, op_bad);
        chk("b2b_result", res, 512'd42);
        chk("b2b_latency", t_rsp - t_hs, 5);
        @(negedge clk);

        // Controller reset while the ALU is PENDING (D=20)
        tr0 = n_trig;
        send(3'd0, 8'd20, 256'd1, 256'd2, t_hs);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            if (rsp_valid) bad++;
            n++;
        end
        chk("rstpend_ready_back", cmd_ready, 1);
        chk("rstpend_ready_time", cyc - t_hs, 24);
        chk("rstpend_alu_idle", alu_status, ST_IDLE);
        chk("rstpend_no_rsp", bad, 0);
        chk("rstpend_no_retrigger", n_trig - tr0, 1);

        // ALU stuck in PENDING -> watchdog timeout
        alu_stuck = 1'b1;
        send(3'd0, 8'd1, 256'd5, 256'd7, t_hs);
        wait_rsp(1200, 256'd5, 256'd7, t_rsp, res, code, op_bad);
        chk("to_code", code, RSP_ERR_TIMEOUT);
        chk("to_result", res, 0);
        chk("to_latency", t_rsp - t_hs, 1028);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (cmd_ready || rsp_valid) bad++;
        end
        chk("to_hold_off_while_busy", bad, 0);
        alu_stuck = 1'b0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_recovered_ready", cmd_ready, 1);
        send(3'd0, 8'd1, 256'd9, 256'd1, t_hs);
        wait_rsp(100, 256'd9, 256'd1, t_rsp, res, code, op_bad);
        chk("post_to_result", res, 512'd10);
        chk("post_to_code", code, RSP_OK);
        @(negedge clk);
        chk("no_we_while_pending", we_in_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wide_alu_ctrl.md
Name: wide_alu_ctrl

Overview:
Initiator-side controller for the wide ALU register interface. It accepts operation commands on a valid/ready handshake, programs the ALU's op-select and de-acceleration factor, triggers the operation and tracks ALU status to completion. It returns the 512-bit result, or an error code, on a valid/ready response channel, and recovers the ALU from error states. It sits between a command source (DMA/regfile front-end) and the wide ALU.

Parameters:
ALU_WIDTH, 256, operand width; result is 2*ALU_WIDTH
DEACCEL_WIDTH, 8, width of de-acceleration factor
TIMEOUT_CYCLES, 1024, max cycles waiting for any ALU status change before timeout error

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_op_i  in  optype_e  requested operation (raw value passed through, may be illegal)
cmd_deaccel_i  in  DEACCEL_WIDTH  requested de-acceleration factor
cmd_op_a_i / cmd_op_b_i  in  ALU_WIDTH  operands
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted when valid&ready
rsp_result_o  out  2*ALU_WIDTH  result (0 on error)
rsp_code_o  out  rsp_code_e  OK / ERR_OPCODE / ERR_WRITE / ERR_TIMEOUT
alu_trigger_o  out  1  ALU trigger pulse
alu_clear_err_o  out  1  ALU error-clear pulse
alu_op_a_o / alu_op_b_o  out  ALU_WIDTH  operands, held stable for whole operation
alu_op_sel_we_o  out  1  op-select write enable
alu_op_sel_o  out  optype_e  op-select write data
alu_deaccel_we_o  out  1  de-acceleration write enable
alu_deaccel_o  out  DEACCEL_WIDTH  de-acceleration write data
alu_status_i  in  status_e  ALU status (IDLE/PENDING/ERROR_WRITE/ERROR_OPCODE)
alu_result_i  in  2*ALU_WIDTH  ALU result

Behaviour:
- Reset values: cmd_ready_o=0, rsp_valid_o=0, rsp_result_o=0, rsp_code_o=OK, all pulses/WEs=0, alu_op_a/b_o=0, alu_op_sel_o=ADD, alu_deaccel_o=1; state=SYNC.
- All outputs registered; ALU WEs, trigger and clear are single-cycle pulses.
- FSM states:
  - SYNC: resynchronise with ALU, which is not reset by rst_i. status IDLE -> IDLE. PENDING -> stay; the ALU completes and its result is discarded. ERROR_* -> CLEAR with no response pending.
  - IDLE: cmd_ready_o=1. On handshake, latch op/operands; deaccel 0 is clamped to 1 (0 would make the ALU run ~256 cycles). -> CFG.
  - CFG: pulse both WEs with the latched values -> TRIG.
  - TRIG: pulse trigger -> WAIT.
  - WAIT: status IDLE (seen after at least one PENDING) -> capture alu_result_i, code OK -> RESP. ERROR_OPCODE/ERROR_WRITE -> record code, result 0 -> CLEAR.
  - CLEAR: pulse clear_err -> CLRWAIT.
  - CLRWAIT: status IDLE -> RESP; in the SYNC-origin case -> IDLE instead.
  - RESP: rsp_valid_o=1; result and code held stable until rsp_ready_i -> IDLE.
- WEs are never issued while ALU status is PENDING; this protocol rule prevents ERROR_WRITE from this master.
- Latency: cmd handshake cycle T. WEs at T+1, trigger at T+2, status PENDING T+3..T+2+D, IDLE at T+3+D, rsp_valid_o at T+4+D. For D=1: T+5.
- Watchdog: counts cycles in WAIT/CLRWAIT/SYNC without a status change. Reaching TIMEOUT_CYCLES in WAIT gives RESP with ERR_TIMEOUT and result 0. In CLRWAIT or SYNC the counter saturates and the FSM keeps waiting.
- Command inputs are ignored outside IDLE. rsp_ready_i is ignored outside RESP.

Decomposition:
- Add to wide_alu_pkg: rsp_code_e (2-bit: OK=0, ERR_OPCODE=1, ERR_WRITE=2, ERR_TIMEOUT=3) and ctrl_state_e.
- Reuse optype_e and status_e from that package.
- No sub-module needed; the watchdog counter stays inline.

Test Plan:
1. ADD a=5, b=7, D=1, rsp_ready=1 -> op_sel WE at T+1, trigger at T+2, rsp_valid at T+5, result=12, code OK.
2. MUL a=2^255, b=2, D=4 -> rsp_valid at T+8, result=2^256, code OK. Operands on alu_op_a/b_o stable T+1..T+7.
3. cmd_op=7 (illegal), D=1 -> ALU ERROR_OPCODE, exactly one clear_err pulse, response code ERR_OPCODE, result 0, ALU back to IDLE.
4. D=0 command -> deaccel written as 1, latency identical to test 1.
5. Hold rsp_ready_i=0 for 10 cycles after rsp_valid -> result/code stable, cmd_ready_o=0. After handshake, a back-to-back command is accepted the next cycle.
6. Assert rst_i during D=20 PENDING -> cmd_ready_o stays 0 until ALU status IDLE, no response emitted. Separately, a bench ALU stuck in PENDING -> ERR_TIMEOUT after 1024 cycles.
